// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the 4-slot TDM receive path
package tdm_pkg;
   localparam int SLOTS = 4;
   typedef logic [1:0] slot_t;
   typedef enum logic {HUNT, LOCKED} tdm_state_t;
   localparam logic [SLOTS-1:0] INV_MASK = 4'b0101;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit frame slot counter plus saturating sync-miss counter
module tdm_slot_ctr
   import tdm_pkg::*;
#(
   parameter int MISS_LIMIT = 3
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  adv_i,
   input  logic  load_i,
   input  logic  clr_i,
   input  logic  miss_inc_i,
   input  logic  miss_clr_i,
   output slot_t slot_o,
   output logic  miss_hit_o
);
   slot_t      slot_q, slot_d;
   logic [2:0] miss_q, miss_d;
   // clear beats load, load beats advance; miss clear beats increment
   always_comb begin
      slot_d = clr_i ? 2'd0 : load_i ? 2'd1 : adv_i ? slot_q + 2'd1 : slot_q;
      miss_d = (clr_i || miss_clr_i) ? 3'd0 : (miss_inc_i && miss_q != 3'd7) ? miss_q + 3'd1 : miss_q;
   end
   // counter state
   always_ff @(posedge clk)
      if (rst) begin
         slot_q <= 2'd0;
         miss_q <= 3'd0;
      end else begin
         slot_q <= slot_d;
         miss_q <= miss_d;
      end
   assign slot_o     = slot_q;
   assign miss_hit_o = miss_q == 3'(MISS_LIMIT - 1);
endmodule

// File: rtl/tdm_demux_1t4.sv
// tdm_demux_1t4: 1:4 TDM demultiplexer with HUNT/LOCKED alignment (TDM_CH_INVERT_EN: ch0/ch2 carried inverted)
module tdm_demux_1t4
   import tdm_pkg::*;
#(
   parameter int WIDTH      = 1,
   parameter int MISS_LIMIT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] ch0,
   output logic [WIDTH-1:0] ch1,
   output logic [WIDTH-1:0] ch2,
   output logic [WIDTH-1:0] ch3,
   output logic             frame_valid,
   output logic             locked,
   output logic             sync_err
);
`ifdef TDM_CH_INVERT_EN
   localparam logic [SLOTS-1:0] INV = INV_MASK;
`else
   localparam logic [SLOTS-1:0] INV = '0;
`endif
   tdm_state_t       state_q, state_d;
   slot_t            slot, idx;
   logic             miss_hit, hunt, slot0, err, drop, store, publish, miss_inc, miss_clr;
   logic             frame_valid_q, sync_err_q;
   logic [WIDTH-1:0] sh_q [SLOTS-1];
   logic [WIDTH-1:0] ch_q [SLOTS];
   tdm_slot_ctr #(.MISS_LIMIT(MISS_LIMIT)) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .adv_i      (store && !sync),
      .load_i     (store && sync),
      .clr_i      (drop),
      .miss_inc_i (miss_inc),
      .miss_clr_i (miss_clr),
      .slot_o     (slot),
      .miss_hit_o (miss_hit)
   );
   // alignment state register
   always_ff @(posedge clk)
      if (rst) state_q <= HUNT;
      else     state_q <= state_d;
   // lock on any sync beat in HUNT; fall back to HUNT when the miss budget runs out
   always_comb begin
      hunt    = state_q == HUNT;
      slot0   = slot == 2'd0;
      err     = din_valid && !hunt && (sync != slot0);
      drop    = err && miss_hit;
      store   = din_valid && (hunt ? sync : !drop);
      state_d = hunt ? (store ? LOCKED : HUNT) : (drop ? HUNT : LOCKED);
   end
   // beat decode: a sync beat always restarts at slot 0, slot 3 without sync completes a frame
   always_comb begin
      idx      = sync ? 2'd0 : slot;
      publish  = store && !sync && slot == 2'd3;
      miss_inc = err && !drop;
      miss_clr = store && sync && slot0;
      locked   = state_q == LOCKED;
   end
   // shadow capture, frame publish and one-cycle strobes
   always_ff @(posedge clk)
      if (rst) begin
         for (int i = 0; i < SLOTS - 1; i++) sh_q[i] <= '0;
         for (int i = 0; i < SLOTS; i++) ch_q[i] <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         if (store && idx != 2'd3) sh_q[idx] <= din;
         if (publish) begin
            for (int i = 0; i < SLOTS - 1; i++) ch_q[i] <= sh_q[i] ^ {WIDTH{INV[i]}};
            ch_q[SLOTS-1] <= din ^ {WIDTH{INV[SLOTS-1]}};
         end
         frame_valid_q <= publish;
         sync_err_q    <= miss_inc;
      end
   assign ch0         = ch_q[0];
   assign ch1         = ch_q[1];
   assign ch2         = ch_q[2];
   assign ch3         = ch_q[3];
   assign frame_valid = frame_valid_q;
   assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux_1t4.sv
// tb_tdm_demux_1t4: directed-vector bench for the TDM demultiplexer
module tb_tdm_demux_1t4;
   logic clk = 1'b0, rst = 1'b1, din = 1'b0, din_valid = 1'b0, sync = 1'b0;
   logic ch0, ch1, ch2, ch3, frame_valid, locked, sync_err;
   int vec = 0, bad = 0;
   logic [3:0] cur = 4'b0000;
`ifdef TDM_CH_INVERT_EN
   localparam logic [3:0] MASK = 4'b1010;
`else
   localparam logic [3:0] MASK = 4'b0000;
`endif
   wire [6:0] obs = {ch0, ch1, ch2, ch3, frame_valid, locked, sync_err};
   always #5 clk = ~clk;
   tdm_demux_1t4 #(.WIDTH(1), .MISS_LIMIT(3)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
      .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
      .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
   );
   task automatic beat(input logic s, input logic d, input logic r = 1'b0);
      @(negedge clk);
      din_valid = 1'b1; sync = s; din = d; rst = r;
      @(negedge clk);
      din_valid = 1'b0; sync = 1'b0; rst = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cur = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (obs !== 7'b0) begin bad++; $display("FAIL reset idle %0d: got %b want %b", i, obs, 7'b0); end
         vec++;
      end
   endtask
   task automatic test_clean_frame();
      logic [8:0] t [4];
      t = '{9'b11_010_0000, 9'b00_010_0000, 9'b01_010_0000, 9'b01_110_1011};
      for (int i = 0; i < 4; i++) begin
         beat(t[i][8], t[i][7]);
         if (t[i][6]) cur = t[i][3:0] ^ MASK;
         if (obs !== {cur, t[i][6:4]}) begin bad++; $display("FAIL clean beat %0d: got %b want %b", i, obs, {cur, t[i][6:4]}); end
         vec++;
      end
      @(negedge clk);
      if (obs !== {cur, 3'b010}) begin bad++; $display("FAIL clean strobe end: got %b want %b", obs, {cur, 3'b010}); end
      vec++;
   endtask
   task automatic test_gaps();
      logic [8:0] t [4];
      t = '{9'b11_010_0000, 9'b00_010_0000, 9'b01_010_0000, 9'b01_110_1011};
      for (int i = 0; i < 4; i++) begin
         beat(t[i][8], t[i][7]);
         if (t[i][6]) cur = t[i][3:0] ^ MASK;
         if (obs !== {cur, t[i][6:4]}) begin bad++; $display("FAIL gaps beat %0d: got %b want %b", i, obs, {cur, t[i][6:4]}); end
         vec++;
         for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            if (obs !== {cur, 3'b010}) begin bad++; $display("FAIL gaps idle %0d.%0d: got %b want %b", i, g, obs, {cur, 3'b010}); end
            vec++;
         end
      end
   endtask
   task automatic test_early_sync();
      logic [8:0] t [10];
      t = '{9'b10_010_0000, 9'b01_010_0000, 9'b11_011_0000, 9'b00_010_0000, 9'b00_010_0000,
            9'b01_110_1001, 9'b10_010_0000, 9'b01_010_0000, 9'b00_010_0000, 9'b00_110_0100};
      for (int i = 0; i < 10; i++) begin
         beat(t[i][8], t[i][7]);
         if (t[i][6]) cur = t[i][3:0] ^ MASK;
         if (obs !== {cur, t[i][6:4]}) begin bad++; $display("FAIL early beat %0d: got %b want %b", i, obs, {cur, t[i][6:4]}); end
         vec++;
      end
   endtask
   task automatic test_loss_of_lock();
      logic [8:0] t [20];
      t = '{9'b10_010_0000, 9'b01_010_0000, 9'b01_010_0000, 9'b00_110_0110,
            9'b01_011_0000, 9'b01_010_0000, 9'b01_010_0000, 9'b01_110_1111,
            9'b00_011_0000, 9'b00_010_0000, 9'b00_010_0000, 9'b01_110_0001,
            9'b01_000_0000, 9'b01_000_0000, 9'b00_000_0000, 9'b01_000_0000,
            9'b11_010_0000, 9'b00_010_0000, 9'b00_010_0000, 9'b00_110_1000};
      for (int i = 0; i < 20; i++) begin
         beat(t[i][8], t[i][7]);
         if (t[i][6]) cur = t[i][3:0] ^ MASK;
         if (obs !== {cur, t[i][6:4]}) begin bad++; $display("FAIL lock beat %0d: got %b want %b", i, obs, {cur, t[i][6:4]}); end
         vec++;
      end
   endtask
   task automatic test_reset_mid_frame();
      logic [8:0] t [2];
      t = '{9'b11_010_0000, 9'b01_010_0000};
      for (int i = 0; i < 2; i++) begin
         beat(t[i][8], t[i][7]);
         if (obs !== {cur, t[i][6:4]}) begin bad++; $display("FAIL midrst beat %0d: got %b want %b", i, obs, {cur, t[i][6:4]}); end
         vec++;
      end
      beat(1'b0, 1'b0, 1'b1);
      cur = 4'b0000;
      if (obs !== 7'b0) begin bad++; $display("FAIL midrst reset: got %b want %b", obs, 7'b0); end
      vec++;
      for (int i = 0; i < 4; i++) begin
         beat(1'b0, 1'b1);
         if (obs !== 7'b0) begin bad++; $display("FAIL midrst hunt %0d: got %b want %b", i, obs, 7'b0); end
         vec++;
      end
   endtask
   initial begin
      test_reset();
      test_clean_frame();
      test_gaps();
      test_early_sync();
      test_loss_of_lock();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
